// File: rtl/aes_ks_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_ks_iter_if
//  Description : Bus bundle for the iterative AES key-schedule block.
//                master drives the key, load strobe and read-port indices;
//                slave returns busy/ready status and the two round keys.
//  Ports       : key_i[KEY_BITS], key_load, index0[4], index[4]  (to slave)
//                busy, ready, rk0[128], rk[128]                  (from slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface aes_ks_iter_if #(
   parameter int KEY_BITS = 128
);
   logic [KEY_BITS-1:0] key_i;
   logic                key_load;
   logic                busy;
   logic                ready;
   logic [3:0]          index0;
   logic [3:0]          index;
   logic [127:0]        rk0;
   logic [127:0]        rk;

   modport master (
      output key_i, key_load, index0, index,
      input  busy, ready, rk0, rk
   );

   modport slave (
      input  key_i, key_load, index0, index,
      output busy, ready, rk0, rk
   );
endinterface
`default_nettype wire

// File: rtl/aes_ks_iter.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox_lut
//  Description : AES forward S-box as a 256-entry constant table.
//  Ports       : a[8] input byte, y[8] substituted byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox_lut (
   input  wire  [7:0] a,
   output logic [7:0] y
);
   // Entry 0 sits in the top byte, so byte a lives at bit offset 8*(255-a).
   localparam logic [2047:0] C_SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = C_SBOX[{~a, 3'b000} +: 8];
endmodule

// ============================================================================
//  Module      : aes_sbox
//  Description : AES S-box computed in GF(2^8): inverse followed by the
//                affine map (dec=0), or inverse affine then inverse (dec=1).
//  Ports       : a[8] input byte, dec direction select, y[8] result byte
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
   input  wire  [7:0] a,
   input  wire        dec,
   output logic [7:0] y
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] xx;
      p  = 8'h00;
      xx = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ xx;
         xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] r;
      sq = x;
      r  = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine_fwd(input logic [7:0] b);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
               ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] affine_inv(input logic [7:0] b);
      return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
   endfunction

   always_comb begin
      if (dec) y = gf_inv(affine_inv(a));
      else     y = affine_fwd(gf_inv(a));
   end
endmodule

// ============================================================================
//  Module      : aes_ks_iter
//  Description : Iterative AES-128/256 key expansion, one word per clock,
//                with two independent combinational round-key read ports.
//  Ports       : clk, rst (sync, active-high)
//                bus.key_i/key_load   : cipher key and start strobe
//                bus.busy/ready       : expansion in progress / keys valid
//                bus.index0/index     : round-key selects
//                bus.rk0/rk           : selected round keys (0 unless valid)
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_ks_iter #(
   parameter int KEY_BITS    = 128,
   parameter int SBOX_GF_SEL = 0
) (
   input wire           clk,
   input wire           rst,
   aes_ks_iter_if.slave bus
);
   localparam int         NK     = KEY_BITS / 32;
   localparam int         NR     = (KEY_BITS == 256) ? 14 : 10;
   localparam int         NW     = 4 * (NR + 1);
   localparam logic [5:0] C_NK   = 6'(NK);
   localparam logic [5:0] C_LAST = 6'(NW - 1);
   localparam logic [3:0] C_NR   = 4'(NR);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [5:0]  wc_q, wc_d;
   logic        busy_q, busy_d;
   logic        ready_q, ready_d;
   logic [31:0] w_q [0:NW-1];

   function automatic logic [7:0] rcon(input logic [5:0] r);
      case (r)
         6'd1:    return 8'h01;
         6'd2:    return 8'h02;
         6'd3:    return 8'h04;
         6'd4:    return 8'h08;
         6'd5:    return 8'h10;
         6'd6:    return 8'h20;
         6'd7:    return 8'h40;
         6'd8:    return 8'h80;
         6'd9:    return 8'h1b;
         6'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------------------------------------------------------- word rule
   logic [5:0]  idx_prev, idx_back;
   logic [31:0] w_prev, w_back, w_sub_in, w_temp, w_new;
   logic        mod_zero, mod_four;
   wire  [31:0] w_sub;

   assign idx_prev = wc_q - 6'd1;
   assign idx_back = wc_q - C_NK;
   assign w_prev   = w_q[idx_prev];
   assign w_back   = w_q[idx_back];
   // NK is a power of two, so wc mod NK is just a mask.
   assign mod_zero = ((wc_q & (C_NK - 6'd1)) == 6'd0);
   assign mod_four = (NK == 8) && (wc_q[2:0] == 3'd4);
   // RotWord is applied before the shared S-boxes only on the Rcon words.
   assign w_sub_in = mod_zero ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign w_temp   = mod_zero ? (w_sub ^ {rcon(wc_q / C_NK), 24'h0}) :
                     mod_four ? w_sub : w_prev;
   assign w_new    = w_back ^ w_temp;

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      if (SBOX_GF_SEL == 1) begin : g_gf
         aes_sbox u_sbox (
            .a   (w_sub_in[8*b +: 8]),
            .dec (1'b0),
            .y   (w_sub[8*b +: 8])
         );
      end else begin : g_lut
         aes_sbox_lut u_sbox (
            .a (w_sub_in[8*b +: 8]),
            .y (w_sub[8*b +: 8])
         );
      end
   end

   // --------------------------------------------------------------- control
   always_comb begin
      state_d = state_q;
      wc_d    = wc_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      if (bus.key_load) begin
         // A new key always wins: any partial or finished schedule is dropped.
         state_d = EXPAND;
         wc_d    = C_NK;
         busy_d  = 1'b1;
         ready_d = 1'b0;
      end else if (state_q == EXPAND) begin
         wc_d = wc_q + 6'd1;
         if (wc_q == C_LAST) begin
            state_d = DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wc_q    <= 6'd0;
         busy_q  <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wc_q    <= wc_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
      end
   end

   // The store is not reset: its contents are only visible while ready=1.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (bus.key_load) begin
            for (int i = 0; i < NK; i++) begin
               w_q[i] <= bus.key_i[KEY_BITS-1-32*i -: 32];
            end
         end else if (state_q == EXPAND) begin
            w_q[wc_q] <= w_new;
         end
      end
   end

   // ------------------------------------------------------------ read ports
   // Out-of-range selects are clamped to 0 so the store read stays in bounds;
   // the output is masked for them anyway.
   logic [5:0]   base0, base1;
   logic [127:0] rk0_w, rk_w;

   always_comb begin
      base0 = (bus.index0 > C_NR) ? 6'd0 : {bus.index0, 2'b00};
      base1 = (bus.index  > C_NR) ? 6'd0 : {bus.index,  2'b00};
      rk0_w = 128'h0;
      rk_w  = 128'h0;
      if (ready_q && (bus.index0 <= C_NR)) begin
         rk0_w = {w_q[base0], w_q[base0 + 6'd1], w_q[base0 + 6'd2], w_q[base0 + 6'd3]};
      end
      if (ready_q && (bus.index <= C_NR)) begin
         rk_w = {w_q[base1], w_q[base1 + 6'd1], w_q[base1 + 6'd2], w_q[base1 + 6'd3]};
      end
   end

   assign bus.rk0   = rk0_w;
   assign bus.rk    = rk_w;
   assign bus.busy  = busy_q;
   assign bus.ready = ready_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_ks_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_ks_iter
//  Description : Directed bench for aes_ks_iter with one AES-128 instance
//                (table S-box) and one AES-256 instance (GF S-box).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_ks_iter;
   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   localparam logic [127:0] K_FIPS   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R10_FIPS = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] K_SP     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1_SP    = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R10_SP   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [255:0] K_256    =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] R0_256   = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] R1_256   = 128'h101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] R14_256  = 128'h24fc79ccbf0979e9371ac23c6d68de36;

   aes_ks_iter_if #(.KEY_BITS(128)) bus128 ();
   aes_ks_iter_if #(.KEY_BITS(256)) bus256 ();

   aes_ks_iter #(.KEY_BITS(128), .SBOX_GF_SEL(0)) u_dut128 (
      .clk (clk),
      .rst (rst),
      .bus (bus128)
   );

   aes_ks_iter #(.KEY_BITS(256), .SBOX_GF_SEL(1)) u_dut256 (
      .clk (clk),
      .rst (rst),
      .bus (bus256)
   );

   task automatic load128(input logic [127:0] k);
      @(negedge clk);
      bus128.key_i    = k;
      bus128.key_load = 1'b1;
      @(posedge clk);
      #1;
      bus128.key_load = 1'b0;
   endtask

   task automatic load256(input logic [255:0] k);
      @(negedge clk);
      bus256.key_i    = k;
      bus256.key_load = 1'b1;
      @(posedge clk);
      #1;
      bus256.key_load = 1'b0;
   endtask

   // Counts edges after the load edge until ready is seen (bounded).
   task automatic wait128(output int n);
      n = 0;
      while (bus128.ready !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic wait256(output int n);
      n = 0;
      while (bus256.ready !== 1'b1 && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic test_reset;
      rst             = 1'b1;
      bus128.key_i    = '0;
      bus128.key_load = 1'b0;
      bus128.index0   = 4'd0;
      bus128.index    = 4'd0;
      bus256.key_i    = '0;
      bus256.key_load = 1'b0;
      bus256.index0   = 4'd0;
      bus256.index    = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus128.busy !== 1'b0 || bus128.ready !== 1'b0) begin
         failures++;
         $display("FAIL reset128_status busy=%b ready=%b required busy=0 ready=0",
                  bus128.busy, bus128.ready);
      end
      checks++;
      if (bus256.busy !== 1'b0 || bus256.ready !== 1'b0) begin
         failures++;
         $display("FAIL reset256_status busy=%b ready=%b required busy=0 ready=0",
                  bus256.busy, bus256.ready);
      end
      for (int i = 0; i < 16; i++) begin
         bus128.index0 = 4'(i);
         bus128.index  = 4'(15 - i);
         bus256.index0 = 4'(i);
         bus256.index  = 4'(15 - i);
         #1;
         checks++;
         if (bus128.rk0 !== 128'h0 || bus128.rk !== 128'h0 ||
             bus256.rk0 !== 128'h0 || bus256.rk !== 128'h0) begin
            failures++;
            $display("FAIL reset_rk_zero i=%0d rk0=%h rk=%h required 0", i,
                     bus128.rk0, bus128.rk);
         end
      end
   endtask

   task automatic test_fips128;
      int n;
      load128(K_FIPS);
      checks++;
      if (bus128.busy !== 1'b1 || bus128.ready !== 1'b0) begin
         failures++;
         $display("FAIL fips128_busy busy=%b ready=%b required busy=1 ready=0",
                  bus128.busy, bus128.ready);
      end
      wait128(n);
      checks++;
      if (n !== 40) begin
         failures++;
         $display("FAIL fips128_latency edges=%0d required 40", n);
      end
      checks++;
      if (bus128.busy !== 1'b0) begin
         failures++;
         $display("FAIL fips128_busy_done busy=%b required 0", bus128.busy);
      end
      bus128.index0 = 4'd0;
      bus128.index  = 4'd10;
      #1;
      checks++;
      if (bus128.rk0 !== K_FIPS) begin
         failures++;
         $display("FAIL fips128_rk0_0 got=%h required=%h", bus128.rk0, K_FIPS);
      end
      checks++;
      if (bus128.rk !== R10_FIPS) begin
         failures++;
         $display("FAIL fips128_rk_10 got=%h required=%h", bus128.rk, R10_FIPS);
      end
   endtask

   task automatic test_sp128;
      int n;
      load128(K_SP);
      wait128(n);
      checks++;
      if (n !== 40) begin
         failures++;
         $display("FAIL sp128_latency edges=%0d required 40", n);
      end
      bus128.index0 = 4'd0;
      bus128.index  = 4'd10;
      #1;
      checks++;
      if (bus128.rk0 !== K_SP) begin
         failures++;
         $display("FAIL sp128_rk0_0 got=%h required=%h", bus128.rk0, K_SP);
      end
      checks++;
      if (bus128.rk !== R10_SP) begin
         failures++;
         $display("FAIL sp128_rk_10 got=%h required=%h", bus128.rk, R10_SP);
      end
      bus128.index0 = 4'd1;
      #1;
      checks++;
      if (bus128.rk0 !== R1_SP) begin
         failures++;
         $display("FAIL sp128_rk0_1 got=%h required=%h", bus128.rk0, R1_SP);
      end
      bus128.index0 = 4'd10;
      #1;
      checks++;
      if (bus128.rk0 !== R10_SP || bus128.rk !== R10_SP) begin
         failures++;
         $display("FAIL sp128_same_index rk0=%h rk=%h required=%h",
                  bus128.rk0, bus128.rk, R10_SP);
      end
   endtask

   task automatic test_done_reload;
      int n;
      load128(K_FIPS);
      checks++;
      if (bus128.ready !== 1'b0 || bus128.busy !== 1'b1) begin
         failures++;
         $display("FAIL done_reload_drop ready=%b busy=%b required ready=0 busy=1",
                  bus128.ready, bus128.busy);
      end
      wait128(n);
      bus128.index = 4'd10;
      #1;
      checks++;
      if (n !== 40 || bus128.rk !== R10_FIPS) begin
         failures++;
         $display("FAIL done_reload_result edges=%0d rk=%h required 40 %h",
                  n, bus128.rk, R10_FIPS);
      end
   endtask

   task automatic test_restart;
      int n;
      int early;
      early = 0;
      load128(K_FIPS);
      repeat (9) begin
         @(posedge clk);
         #1;
         if (bus128.ready !== 1'b0) early++;
      end
      load128(K_SP);
      if (bus128.ready !== 1'b0) early++;
      wait128(n);
      checks++;
      if (early !== 0) begin
         failures++;
         $display("FAIL restart_ready_low early_ready_cycles=%0d required 0", early);
      end
      checks++;
      if (n !== 40) begin
         failures++;
         $display("FAIL restart_latency edges=%0d required 40", n);
      end
      bus128.index = 4'd10;
      #1;
      checks++;
      if (bus128.rk !== R10_SP) begin
         failures++;
         $display("FAIL restart_rk_10 got=%h required=%h", bus128.rk, R10_SP);
      end
   endtask

   task automatic test_aes256;
      int n;
      load256(K_256);
      wait256(n);
      checks++;
      if (n !== 52) begin
         failures++;
         $display("FAIL aes256_latency edges=%0d required 52", n);
      end
      bus256.index0 = 4'd1;
      bus256.index  = 4'd14;
      #1;
      checks++;
      if (bus256.rk0 !== R1_256) begin
         failures++;
         $display("FAIL aes256_rk0_1 got=%h required=%h", bus256.rk0, R1_256);
      end
      checks++;
      if (bus256.rk !== R14_256) begin
         failures++;
         $display("FAIL aes256_rk_14 got=%h required=%h", bus256.rk, R14_256);
      end
      bus256.index0 = 4'd0;
      bus256.index  = 4'd15;
      #1;
      checks++;
      if (bus256.rk0 !== R0_256) begin
         failures++;
         $display("FAIL aes256_rk0_0 got=%h required=%h", bus256.rk0, R0_256);
      end
      checks++;
      if (bus256.rk !== 128'h0) begin
         failures++;
         $display("FAIL aes256_rk_15 got=%h required 0", bus256.rk);
      end
   endtask

   task automatic test_bounds_reset;
      bus128.index0 = 4'd10;
      bus128.index  = 4'd11;
      #1;
      checks++;
      if (bus128.rk !== 128'h0) begin
         failures++;
         $display("FAIL bounds_rk_11 got=%h required 0", bus128.rk);
      end
      checks++;
      if (bus128.rk0 !== R10_SP) begin
         failures++;
         $display("FAIL bounds_rk0_10 got=%h required=%h", bus128.rk0, R10_SP);
      end
      bus128.index = 4'd15;
      #1;
      checks++;
      if (bus128.rk !== 128'h0) begin
         failures++;
         $display("FAIL bounds_rk_15 got=%h required 0", bus128.rk);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (bus128.ready !== 1'b0 || bus128.busy !== 1'b0 || bus128.rk0 !== 128'h0) begin
         failures++;
         $display("FAIL bounds_reset ready=%b busy=%b rk0=%h required 0 0 0",
                  bus128.ready, bus128.busy, bus128.rk0);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus128.ready !== 1'b0 || bus128.rk0 !== 128'h0) begin
         failures++;
         $display("FAIL bounds_reset_hold ready=%b rk0=%h required 0 0",
                  bus128.ready, bus128.rk0);
      end
   endtask

   task automatic test_rst_abort;
      int seen;
      seen = 0;
      load256(K_256);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (bus256.busy !== 1'b0 || bus256.ready !== 1'b0) begin
         failures++;
         $display("FAIL abort_status busy=%b ready=%b required 0 0",
                  bus256.busy, bus256.ready);
      end
      repeat (80) begin
         @(posedge clk);
         #1;
         if (bus256.ready !== 1'b0 || bus256.busy !== 1'b0) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL abort_stays_idle active_cycles=%0d required 0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_fips128();
      test_sp128();
      test_done_reload();
      test_restart();
      test_aes256();
      test_bounds_reset();
      test_rst_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/aes_ks_iter.md
AES_KS_ITER -- requirements
Module: aes_ks_iter

Interface
REQ-001: Parameter KEY_BITS, default 128; selects key size, legal values 128 or 256 only; derived NK = KEY_BITS/32 (4 or 8) and NR = 10 or 14.
REQ-002: Parameter SBOX_GF_SEL, default 0; 0 instantiates aes_sbox_lut, 1 instantiates aes_sbox; the encrypt direction is tied with dec=0.
REQ-003: clk  input  1  the single clock; all state updates on the rising edge.
REQ-004: rst  input  1  reset, synchronous and active-high.
REQ-005: key_i  input  KEY_BITS  cipher key; bits [KEY_BITS-1 -: 32] form word w[0].
REQ-006: key_load  input  1  single-cycle strobe; samples key_i and starts expansion.
REQ-007: busy  output  1  high while expansion is in progress.
REQ-008: ready  output  1  high when all round keys are valid.
REQ-009: index0  input  4  round-key select for read port 0.
REQ-010: index  input  4  round-key select for read port 1.
REQ-011: rk0  output  128  round key index0, which is {w[4*index0], w[4*index0+1], w[4*index0+2], w[4*index0+3]}.
REQ-012: rk  output  128  round key index, with the same word layout as rk0.

Function
REQ-013: The block SHALL hold the states IDLE, EXPAND and DONE, plus a word counter wc (6 bits) and a word store of 4*(NR+1) 32-bit entries (44 or 60).
REQ-014: On a key_load edge in any state, the block SHALL write w[0..NK-1] from key_i, set wc=NK and enter EXPAND.
REQ-015: In EXPAND, each edge SHALL write exactly one word w[wc] and increment wc.
REQ-016: Word rule, temp = w[wc-1]: if wc mod NK == 0, temp = SubWord(RotWord(temp)) ^ {Rcon[wc/NK], 24'h0}; else if NK == 8 and wc mod 8 == 4, temp = SubWord(temp); then w[wc] = w[wc-NK] ^ temp.
REQ-017: RotWord(x) SHALL be {x[23:0], x[31:24]}; SubWord SHALL apply the S-box bytewise through exactly four S-box instances shared across all cycles.
REQ-018: Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-019: On the edge that writes the final word w[4*NR+3], the block SHALL enter DONE.
REQ-020: Latency: ready SHALL rise exactly 4*(NR+1)-NK edges after the key_load edge (40 for AES-128, 52 for AES-256).
REQ-021: busy SHALL be 1 exactly in EXPAND, and ready SHALL be 1 exactly in DONE; the two are never both 1.
REQ-022: A key_load during EXPAND SHALL discard the partial schedule and restart from the new key, with ready held at 0.
REQ-023: A key_load in DONE SHALL drop ready on that edge and restart the expansion.
REQ-024: rk0 and rk SHALL be combinational from the store and equal 128'h0 when ready=0 or the selected index > NR.
REQ-025: The two read ports SHALL be independent and may select the same index.
REQ-026: Expansion SHALL proceed regardless of index0 or index activity.

Reset
REQ-027: While rst=1 at an edge, the block SHALL set state=IDLE, busy=0, ready=0 and wc=0; rst SHALL take priority over key_load.
REQ-028: Store contents need not be reset, because they are masked by ready=0 (REQ-024).
REQ-029: rst asserted mid-EXPAND SHALL abort the expansion; a fresh key_load is required afterwards.

Verification
REQ-030: Reset: assert rst for 2 cycles, then idle -> busy=0, ready=0, rk=rk0=0 for all indices.
REQ-031: KEY_BITS=128, key 000102030405060708090a0b0c0d0e0f -> ready rises 40 edges after the load, and index=10 gives rk=13111d7fe3944a17f307a78b4d2b30c5.
REQ-032: KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c -> index0=0 returns the key, and index=10 gives rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-033: KEY_BITS=256, key 000102...1f -> ready rises after 52 edges, index=1 gives 101112131415161718191a1b1c1d1e1f, and index=14 gives 24fc79ccbf0979e9371ac23c6d68de36.
REQ-034: Load key A, then load key B 10 cycles later -> ready stays 0, rises 40 edges after B's load, and rk matches key B's schedule.
REQ-035: In DONE with the 128-bit key, set index=11 or 15 -> rk=0; assert rst one cycle -> ready=0 and rk0=0 on the next cycle.
